// File: rtl/execute_mdu_if.sv
// Decode-to-execute and execute-to-memory bundles of the execute stage.
// slave: the execute stage; master: whichever neighbour or bench drives it.
interface execute_mdu_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rs_in;
  logic [31:0] rt_in;
  logic [31:0] imm_in;
  logic        imm_en;
  logic [31:0] fwd_exe;
  logic [31:0] fwd_mem;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic [3:0]  alu_op;
  logic [2:0]  md_op;
  logic        trap_ovf;
  logic [4:0]  shamt_in;
  logic [1:0]  st_size;
  logic        ld_en;
  logic [4:0]  wreg_in;
  logic        wen_in;
  logic [31:0] pc_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [31:0] st_data;
  logic [1:0]  st_size_out;
  logic        ld_en_out;
  logic [4:0]  wreg_out;
  logic        wen_out;
  logic [31:0] pc_out;
  logic        ovf;
  logic        busy;

  modport slave (
    input  in_valid, rs_in, rt_in, imm_in, imm_en, fwd_exe, fwd_mem, fwd_a_sel, fwd_b_sel,
           alu_op, md_op, trap_ovf, shamt_in, st_size, ld_en, wreg_in, wen_in, pc_in, out_ready,
    output in_ready, out_valid, result, st_data, st_size_out, ld_en_out, wreg_out, wen_out,
           pc_out, ovf, busy
  );

  modport master (
    output in_valid, rs_in, rt_in, imm_in, imm_en, fwd_exe, fwd_mem, fwd_a_sel, fwd_b_sel,
           alu_op, md_op, trap_ovf, shamt_in, st_size, ld_en, wreg_in, wen_in, pc_in, out_ready,
    input  in_ready, out_valid, result, st_data, st_size_out, ld_en_out, wreg_out, wen_out,
           pc_out, ovf, busy
  );
endinterface

// File: rtl/execute_mdu_stage.sv
// Execute stage: ID/EX register with forwarding, single-cycle ALU, pipelined multiplier,
// iterative restoring divider and the HI/LO registers.
module execute_mdu_stage #(
  parameter int unsigned MUL_LAT  = 3,
  parameter int unsigned DIV_BITS = 1,
  parameter bit          FWD_EN   = 1'b1
) (
  input logic          clk,
  input logic          rstn,
  input logic          flush,
  execute_mdu_if.slave bus
);
  localparam int unsigned DIV_CYC = 32 / DIV_BITS;
  localparam int unsigned CNT_W   = 5;

  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               occupied_q, occupied_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [31:0]        op_a_q, op_a_d, op_b_q, op_b_d;
  logic [2:0]         md_op_q, md_op_d;
  logic [31:0]        result_q, result_d, st_data_q, st_data_d, pc_q, pc_d;
  logic [1:0]         st_size_q, st_size_d;
  logic               ld_en_q, ld_en_d, wen_q, wen_d, ovf_q, ovf_d;
  logic [4:0]         wreg_q, wreg_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [63:0]        prod_q [MUL_LAT];
  logic [63:0]        prod_d [MUL_LAT];
  logic [31:0]        div_rem_q, div_rem_d, div_quo_q, div_quo_d, div_den_q, div_den_d;
  logic               div_qneg_q, div_qneg_d, div_rneg_q, div_rneg_d;

  logic        fire_c, in_ready_c, cap_c, is_md_c;
  logic [31:0] a_c, b_c, alu_res_c, st_lane_c, div_q_c, div_r_c;
  logic        alu_ovf_c;
  logic [63:0] a_ext_c, b_ext_c;
  logic [31:0] rem_t, quo_t;
  logic [32:0] sh_t;

  // Handshake: a draining result frees the slot in the same cycle.
  assign fire_c     = out_valid_q & bus.out_ready;
  assign in_ready_c = !occupied_q | fire_c;
  assign cap_c      = bus.in_valid & in_ready_c & !flush;
  assign is_md_c    = (bus.md_op >= MD_MULT) && (bus.md_op <= MD_DIVU);

  // Operand selection with optional forwarding.
  always_comb begin
    a_c = bus.rs_in;
    b_c = bus.rt_in;
    if (FWD_EN) begin
      case (bus.fwd_a_sel)
        2'b01:   a_c = bus.fwd_exe;
        2'b10:   a_c = bus.fwd_mem;
        default: a_c = bus.rs_in;
      endcase
      case (bus.fwd_b_sel)
        2'b01:   b_c = bus.fwd_exe;
        2'b10:   b_c = bus.fwd_mem;
        default: b_c = bus.rt_in;
      endcase
    end
    if (bus.imm_en) b_c = bus.imm_in;
  end

  // Signed divide fix-up of the magnitude results.
  assign div_q_c = div_qneg_q ? 32'(-div_quo_q) : div_quo_q;
  assign div_r_c = div_rneg_q ? 32'(-div_rem_q) : div_rem_q;

  // HI/LO update; MFHI/MFLO read the next value so a same-edge write is visible.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (!flush) begin
      if (state_q == S_DONE) begin
        if (md_op_q == MD_MULT || md_op_q == MD_MULTU) begin
          {hi_d, lo_d} = prod_q[MUL_LAT-1];
        end else if (op_b_q == 32'h0) begin
          lo_d = 32'hFFFF_FFFF;
          hi_d = op_a_q;
        end else begin
          lo_d = div_q_c;
          hi_d = div_r_c;
        end
      end else if (fire_c && md_op_q == MD_MTHI) begin
        hi_d = op_a_q;
      end else if (fire_c && md_op_q == MD_MTLO) begin
        lo_d = op_a_q;
      end
    end
  end

  always_comb begin
    alu_res_c = 32'h0;
    alu_ovf_c = 1'b0;
    case (bus.alu_op)
      4'd0: begin
        alu_res_c = a_c + b_c;
        alu_ovf_c = (a_c[31] == b_c[31]) && (alu_res_c[31] != a_c[31]);
      end
      4'd1: begin
        alu_res_c = a_c - b_c;
        alu_ovf_c = (a_c[31] != b_c[31]) && (alu_res_c[31] != a_c[31]);
      end
      4'd2:    alu_res_c = a_c & b_c;
      4'd3:    alu_res_c = a_c | b_c;
      4'd4:    alu_res_c = a_c ^ b_c;
      4'd5:    alu_res_c = ~(a_c | b_c);
      4'd6:    alu_res_c = {31'h0, $signed(a_c) < $signed(b_c)};
      4'd7:    alu_res_c = {31'h0, a_c < b_c};
      4'd8:    alu_res_c = b_c << bus.shamt_in;
      4'd9:    alu_res_c = b_c >> bus.shamt_in;
      4'd10:   alu_res_c = 32'($signed(b_c) >>> bus.shamt_in);
      4'd11:   alu_res_c = {b_c[15:0], 16'h0};
      4'd12:   alu_res_c = hi_d;
      4'd13:   alu_res_c = lo_d;
      default: alu_res_c = 32'h0;
    endcase
  end

  always_comb begin
    case (bus.st_size)
      2'd1:    st_lane_c = {4{b_c[7:0]}};
      2'd2:    st_lane_c = {2{b_c[15:0]}};
      2'd3:    st_lane_c = b_c;
      default: st_lane_c = 32'h0;
    endcase
  end

  // Multiplier pipeline: sign/zero-extended 64-bit product, MUL_LAT stages deep.
  always_comb begin
    a_ext_c   = {{32{(md_op_q == MD_MULT) & op_a_q[31]}}, op_a_q};
    b_ext_c   = {{32{(md_op_q == MD_MULT) & op_b_q[31]}}, op_b_q};
    prod_d[0] = a_ext_c * b_ext_c;
    for (int i = 1; i < int'(MUL_LAT); i++) prod_d[i] = prod_q[i-1];
  end

  // Restoring divider on magnitudes, DIV_BITS quotient bits per cycle.
  always_comb begin
    div_rem_d  = div_rem_q;
    div_quo_d  = div_quo_q;
    div_den_d  = div_den_q;
    div_qneg_d = div_qneg_q;
    div_rneg_d = div_rneg_q;
    rem_t      = div_rem_q;
    quo_t      = div_quo_q;
    sh_t       = 33'h0;
    if (cap_c && is_md_c) begin
      div_rem_d  = 32'h0;
      div_quo_d  = (bus.md_op == MD_DIV && a_c[31]) ? 32'(-a_c) : a_c;
      div_den_d  = (bus.md_op == MD_DIV && b_c[31]) ? 32'(-b_c) : b_c;
      div_qneg_d = (bus.md_op == MD_DIV) && (a_c[31] ^ b_c[31]);
      div_rneg_d = (bus.md_op == MD_DIV) && a_c[31];
    end else if (state_q == S_DIV) begin
      for (int i = 0; i < int'(DIV_BITS); i++) begin
        sh_t  = {rem_t, quo_t[31]};
        quo_t = {quo_t[30:0], 1'b0};
        if (sh_t >= {1'b0, div_den_q}) begin
          sh_t     = sh_t - {1'b0, div_den_q};
          quo_t[0] = 1'b1;
        end
        rem_t = sh_t[31:0];
      end
      div_rem_d = rem_t;
      div_quo_d = quo_t;
    end
  end

  // MDU sequencer and stage occupancy.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    occupied_d  = occupied_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (cap_c && is_md_c) begin
          if (bus.md_op == MD_MULT || bus.md_op == MD_MULTU) begin
            state_d = S_MUL;
            cnt_d   = CNT_W'(MUL_LAT - 1);
          end else begin
            state_d = S_DIV;
            cnt_d   = CNT_W'(DIV_CYC - 1);
          end
        end
      end
      S_MUL, S_DIV: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d     = S_IDLE;
      occupied_d  = 1'b0;
      out_valid_d = 1'b0;
    end else if (cap_c) begin
      occupied_d  = 1'b1;
      out_valid_d = !is_md_c;
    end else if (fire_c) begin
      occupied_d  = 1'b0;
      out_valid_d = 1'b0;
    end else if (state_d == S_DONE) begin
      out_valid_d = 1'b1;
    end
    busy_d = (state_d == S_MUL) || (state_d == S_DIV);
  end

  // ID/EX capture; outputs hold until the next capture.
  always_comb begin
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    md_op_d   = md_op_q;
    result_d  = result_q;
    st_data_d = st_data_q;
    st_size_d = st_size_q;
    ld_en_d   = ld_en_q;
    wreg_d    = wreg_q;
    wen_d     = wen_q;
    pc_d      = pc_q;
    ovf_d     = ovf_q;
    if (cap_c) begin
      op_a_d    = a_c;
      op_b_d    = b_c;
      md_op_d   = bus.md_op;
      result_d  = alu_res_c;
      st_data_d = st_lane_c;
      st_size_d = bus.st_size;
      ld_en_d   = bus.ld_en;
      wreg_d    = bus.wreg_in;
      pc_d      = bus.pc_in;
      ovf_d     = bus.trap_ovf & alu_ovf_c;
      wen_d     = bus.wen_in & !(bus.trap_ovf & alu_ovf_c) & !is_md_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      occupied_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      md_op_q     <= '0;
      result_q    <= '0;
      st_data_q   <= '0;
      st_size_q   <= '0;
      ld_en_q     <= 1'b0;
      wreg_q      <= '0;
      wen_q       <= 1'b0;
      pc_q        <= '0;
      ovf_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      div_rem_q   <= '0;
      div_quo_q   <= '0;
      div_den_q   <= '0;
      div_qneg_q  <= 1'b0;
      div_rneg_q  <= 1'b0;
      for (int i = 0; i < int'(MUL_LAT); i++) prod_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      occupied_q  <= occupied_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      md_op_q     <= md_op_d;
      result_q    <= result_d;
      st_data_q   <= st_data_d;
      st_size_q   <= st_size_d;
      ld_en_q     <= ld_en_d;
      wreg_q      <= wreg_d;
      wen_q       <= wen_d;
      pc_q        <= pc_d;
      ovf_q       <= ovf_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      div_rem_q   <= div_rem_d;
      div_quo_q   <= div_quo_d;
      div_den_q   <= div_den_d;
      div_qneg_q  <= div_qneg_d;
      div_rneg_q  <= div_rneg_d;
      for (int i = 0; i < int'(MUL_LAT); i++) prod_q[i] <= prod_d[i];
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = busy_q;
  assign bus.result      = result_q;
  assign bus.st_data     = st_data_q;
  assign bus.st_size_out = st_size_q;
  assign bus.ld_en_out   = ld_en_q;
  assign bus.wreg_out    = wreg_q;
  assign bus.wen_out     = wen_q;
  assign bus.pc_out      = pc_q;
  assign bus.ovf         = ovf_q;
endmodule
